// File: rtl/cfg_node_pkg.sv
// Shared types and elaboration-time helpers for the daisy-chained config node.
// Latency: none (types and constant functions only).
// Backpressure: none; consumers accept a beat every cycle.
package cfg_node_pkg;

    // Frame-level state of a node. CHK is only entered when CFG_NODE_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        CHK  = 3'd3,
        CMT  = 3'd4
    } state_t;

    // Number of beats needed to carry 'bits' bits over 'lanes' lanes.
    function automatic int ceil_div(input int bits, input int lanes);
        return (bits + lanes - 1) / lanes;
    endfunction

    // All-ones ID of the given width; frames carrying it address every node.
    function automatic logic [63:0] bcast_id(input int width);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Width of a beat counter able to index both the header and payload phases.
    function automatic int cnt_width(input int cfg_size, input int lanes, input int id_width);
        int max_beats;
        max_beats = ceil_div(id_width, lanes);
        if (ceil_div(cfg_size, lanes) > max_beats) max_beats = ceil_div(cfg_size, lanes);
        return (max_beats > 1) ? $clog2(max_beats) : 1;
    endfunction

endpackage

// File: rtl/cfg_node_rx.sv
// Frame receiver: beat counter, header ID accumulator and hit decision, optional lane parity.
// Latency: last_hdr/last_pay/parity_ok are combinational on the current beat; hit is registered.
// Backpressure: none; one beat is consumed every cycle. Optional macro: CFG_NODE_PARITY_EN.
module cfg_node_rx
    import cfg_node_pkg::*;
#(
    parameter int CFG_SIZE = 64,
    parameter int LANES    = 1,
    parameter int ID_WIDTH = 8,
    parameter int ID       = 7,
    parameter int CNT_W    = cnt_width(CFG_SIZE, LANES, ID_WIDTH)
) (
    input  logic             clk,
    input  logic             crst,
    input  state_t           i_state,
    input  logic             i_start,
    input  logic [LANES-1:0] i_beat,
    output logic             o_hit,
    output logic             o_last_hdr,
    output logic             o_last_pay,
`ifdef CFG_NODE_PARITY_EN
    output logic             o_parity_ok,
`endif
    output logic [CNT_W-1:0] o_idx
);

    localparam int                ID_BEATS  = ceil_div(ID_WIDTH, LANES);
    localparam int                PAY_BEATS = ceil_div(CFG_SIZE, LANES);
    localparam logic [CNT_W-1:0]  ID_LAST   = CNT_W'(ID_BEATS - 1);
    localparam logic [CNT_W-1:0]  PAY_LAST  = CNT_W'(PAY_BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ID_WIDTH-1:0] BCAST   = ID_WIDTH'(bcast_id(ID_WIDTH));
    localparam logic [ID_WIDTH-1:0] MY_ID   = ID_WIDTH'(ID);

    logic [CNT_W-1:0]    r_cnt;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_hit;

    logic [CNT_W-1:0]    w_idx;
    logic [ID_WIDTH-1:0] w_id;
    logic                w_in_hdr;
    logic                w_in_pay;
    logic                w_last_hdr;
    logic                w_last_pay;

    // Classify the current beat; a start beat is always header beat 0, whatever the state.
    always_comb begin
        w_in_hdr   = i_start || (i_state == HDR);
        w_in_pay   = !i_start && (i_state == PAY);
        w_idx      = i_start ? '0 : r_cnt;
        w_last_hdr = w_in_hdr && (w_idx == ID_LAST);
        w_last_pay = w_in_pay && (r_cnt == PAY_LAST);
        w_id       = '0;
        for (int b = 0; b < ID_WIDTH; b++) begin
            if (w_idx == CNT_W'(b / LANES)) w_id[b] = i_beat[b % LANES];
            else                            w_id[b] = i_start ? 1'b0 : r_id[b];
        end
    end

    // Advance the beat counter and accumulate the ID; decide the hit on the last header beat.
    always_ff @(posedge clk) begin
        if (crst) begin
            r_cnt <= '0;
            r_id  <= '0;
            r_hit <= 1'b0;
        end else if (w_in_hdr) begin
            r_id <= w_id;
            if (w_last_hdr) begin
                r_hit <= (w_id == MY_ID) || (w_id == BCAST);
                r_cnt <= '0;
            end else begin
                r_cnt <= w_idx + CNT_ONE;
            end
        end else if (w_in_pay) begin
            r_cnt <= w_last_pay ? '0 : (r_cnt + CNT_ONE);
        end
    end

`ifdef CFG_NODE_PARITY_EN
    logic [LANES-1:0] r_par;

    // Per-lane running XOR over every header and payload beat of the current frame.
    always_ff @(posedge clk) begin
        if (crst) begin
            r_par <= '0;
        end else if (i_start) begin
            r_par <= i_beat;
        end else if ((i_state == HDR) || (i_state == PAY)) begin
            r_par <= r_par ^ i_beat;
        end
    end

    assign o_parity_ok = (i_beat == r_par);
`endif

    assign o_hit      = r_hit;
    assign o_last_hdr = w_last_hdr;
    assign o_last_pay = w_last_pay;
    assign o_idx      = r_cnt;

endmodule

// File: rtl/cfg_node_mlane.sv
// Daisy-chained config node: ID-addressed multi-lane frames load a shadow, committed to cfg.
// Latency: forwarding 1 cycle; cfg/cfg_sr_pulse update 1 cycle after the final frame beat's edge.
// Backpressure: none; every beat is consumed and forwarded. Optional macro: CFG_NODE_PARITY_EN.
module cfg_node_mlane
    import cfg_node_pkg::*;
#(
    parameter int CFG_SIZE = 64,
    parameter int LANES    = 1,
    parameter int ID_WIDTH = 8,
    parameter int ID       = 7
) (
    input  logic                clk,
    input  logic                crst,
    input  logic                cfg_in_start,
    input  logic [LANES-1:0]    cfg_bit_in,
    output logic                cfg_out_start,
    output logic [LANES-1:0]    cfg_bit_out,
    output logic [CFG_SIZE-1:0] cfg,
    output logic                cfg_sr_pulse,
    output logic                cfg_busy,
    output logic                cfg_err
);

    localparam int CNT_W = cnt_width(CFG_SIZE, LANES, ID_WIDTH);

    state_t              r_state;
    state_t              w_next;
    logic [CFG_SIZE-1:0] r_shadow;
    logic [CFG_SIZE-1:0] r_cfg;
    logic                r_pulse;
    logic                r_fwd_start;
    logic [LANES-1:0]    r_fwd_bits;

    logic                w_hit;
    logic                w_last_hdr;
    logic                w_last_pay;
    logic [CNT_W-1:0]    w_pay_idx;
`ifdef CFG_NODE_PARITY_EN
    logic                w_parity_ok;
    logic                w_err_set;
    logic                r_err;
`endif

    cfg_node_rx #(
        .CFG_SIZE (CFG_SIZE),
        .LANES    (LANES),
        .ID_WIDTH (ID_WIDTH),
        .ID       (ID),
        .CNT_W    (CNT_W)
    ) u_rx (
        .clk         (clk),
        .crst        (crst),
        .i_state     (r_state),
        .i_start     (cfg_in_start),
        .i_beat      (cfg_bit_in),
        .o_hit       (w_hit),
        .o_last_hdr  (w_last_hdr),
        .o_last_pay  (w_last_pay),
`ifdef CFG_NODE_PARITY_EN
        .o_parity_ok (w_parity_ok),
`endif
        .o_idx       (w_pay_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (crst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state: a start beat always opens a new frame (aborting one in flight, if any).
    always_comb begin
        w_next = r_state;
`ifdef CFG_NODE_PARITY_EN
        w_err_set = 1'b0;
`endif
        if (cfg_in_start) begin
            w_next = w_last_hdr ? PAY : HDR;
        end else begin
            case (r_state)
                IDLE: w_next = IDLE;
                HDR:  if (w_last_hdr) w_next = PAY;
`ifdef CFG_NODE_PARITY_EN
                PAY:  if (w_last_pay) w_next = CHK;
                CHK: begin
                    if (w_parity_ok) begin
                        w_next = CMT;
                    end else begin
                        w_next    = IDLE;
                        w_err_set = w_hit;
                    end
                end
`else
                PAY:  if (w_last_pay) w_next = CMT;
                CHK:  w_next = IDLE;
`endif
                CMT:  w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Payload beats of an addressed frame land in the shadow; cfg itself is untouched here.
    always_ff @(posedge clk) begin
        if (crst) begin
            r_shadow <= '0;
        end else if ((r_state == PAY) && !cfg_in_start && w_hit) begin
            for (int b = 0; b < CFG_SIZE; b++) begin
                if (w_pay_idx == CNT_W'(b / LANES)) r_shadow[b] <= cfg_bit_in[b % LANES];
            end
        end
    end

    // Commit the shadow and raise the one-cycle strobe when an addressed frame completes.
    always_ff @(posedge clk) begin
        if (crst) begin
            r_cfg   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= (r_state == CMT) && w_hit;
            if ((r_state == CMT) && w_hit) r_cfg <= r_shadow;
        end
    end

    // Pass every beat down the chain unchanged, one cycle later.
    always_ff @(posedge clk) begin
        if (crst) begin
            r_fwd_start <= 1'b0;
            r_fwd_bits  <= '0;
        end else begin
            r_fwd_start <= cfg_in_start;
            r_fwd_bits  <= cfg_bit_in;
        end
    end

`ifdef CFG_NODE_PARITY_EN
    // Sticky parity error, raised only by frames addressed to this node.
    always_ff @(posedge clk) begin
        if (crst)           r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
    end

    assign cfg_err = r_err;
`else
    assign cfg_err = 1'b0;
`endif

    assign cfg_out_start = r_fwd_start;
    assign cfg_bit_out   = r_fwd_bits;
    assign cfg           = r_cfg;
    assign cfg_sr_pulse  = r_pulse;
    assign cfg_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cfg_node_mlane.sv
// Bench for cfg_node_mlane: two nodes (1 lane / 8-bit cfg, 4 lanes / 10-bit cfg) under random frames.
// Latency: expected commits are queued with the cycle they must appear in.
// Backpressure: none; the driver presents one beat per cycle.
module tb_cfg_node_mlane;

    localparam int A_L = 1, A_C = 8, B_L = 4, B_C = 10, IDW = 4;
    localparam logic [3:0] NODE_ID = 4'h7;
`ifdef CFG_NODE_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst      [2];
    logic        in_start [2];
    logic [3:0]  in_bits  [2];

    logic        a_os, b_os, a_pulse, b_pulse, a_busy, b_busy, a_err, b_err;
    logic [0:0]  a_ob;
    logic [3:0]  b_ob;
    logic [7:0]  a_cfg;
    logic [9:0]  b_cfg;

    logic [15:0] cfg_o   [2];
    logic [3:0]  fo_bits [2];
    logic        fo_st   [2];
    logic        pulse_o [2];
    logic        busy_o  [2];
    logic        err_o   [2];

    assign cfg_o[0]   = {8'h00, a_cfg};
    assign cfg_o[1]   = {6'h00, b_cfg};
    assign fo_bits[0] = {3'b000, a_ob};
    assign fo_bits[1] = b_ob;
    assign fo_st[0]   = a_os;
    assign fo_st[1]   = b_os;
    assign pulse_o[0] = a_pulse;
    assign pulse_o[1] = b_pulse;
    assign busy_o[0]  = a_busy;
    assign busy_o[1]  = b_busy;
    assign err_o[0]   = a_err;
    assign err_o[1]   = b_err;

    cfg_node_mlane #(.CFG_SIZE(A_C), .LANES(A_L), .ID_WIDTH(IDW), .ID(7)) u_dut_a (
        .clk           (clk),
        .crst          (rst[0]),
        .cfg_in_start  (in_start[0]),
        .cfg_bit_in    (in_bits[0][0:0]),
        .cfg_out_start (a_os),
        .cfg_bit_out   (a_ob),
        .cfg           (a_cfg),
        .cfg_sr_pulse  (a_pulse),
        .cfg_busy      (a_busy),
        .cfg_err       (a_err)
    );

    cfg_node_mlane #(.CFG_SIZE(B_C), .LANES(B_L), .ID_WIDTH(IDW), .ID(7)) u_dut_b (
        .clk           (clk),
        .crst          (rst[1]),
        .cfg_in_start  (in_start[1]),
        .cfg_bit_in    (in_bits[1]),
        .cfg_out_start (b_os),
        .cfg_bit_out   (b_ob),
        .cfg           (b_cfg),
        .cfg_sr_pulse  (b_pulse),
        .cfg_busy      (b_busy),
        .cfg_err       (b_err)
    );

    int          vectors = 0;
    int          fails   = 0;
    int          cyc     = 0;
    int          last_e  = 0;
    int          busy_chk = -1;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [15:0] exp_cfg  [2];
    int          err_from [2];
    logic        p_st  [2];
    logic [3:0]  p_bits[2];
    logic        p_rst [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s node%0d cyc=%0d got=%h want=%h", name, inst, cyc, act, exp);
        end
    endtask

    // Monitor: compares every DUT output against the model, once per cycle per node.
    task automatic check_inst(input int i);
        exp_t       e;
        bit         has;
        bit         exp_p;
        logic [3:0] lm;
        lm = (i == 0) ? 4'h1 : 4'hF;
        if (p_rst[i]) begin
            exp_cfg[i]  = '0;
            err_from[i] = -1;
            if (i == 0) q0.delete(); else q1.delete();
            cmp("busy_after_rst", i, 16'(busy_o[i]), 16'h0);
        end
        cmp("fwd_start", i, 16'(fo_st[i]), p_rst[i] ? 16'h0 : 16'(p_st[i]));
        cmp("fwd_bits", i, 16'(fo_bits[i]), p_rst[i] ? 16'h0 : 16'(p_bits[i] & lm));
        has = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        e.val = '0;
        e.cyc = -1;
        if (has) e = (i == 0) ? q0[0] : q1[0];
        exp_p = has && (e.cyc <= cyc);
        cmp("pulse", i, 16'(pulse_o[i]), 16'(exp_p));
        if (exp_p) begin
            exp_cfg[i] = e.val;
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        cmp("cfg", i, cfg_o[i], exp_cfg[i]);
        cmp("err", i, 16'(err_o[i]), 16'((err_from[i] >= 0) && (cyc >= err_from[i])));
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            p_st[i]   = in_start[i];
            p_bits[i] = in_bits[i];
            p_rst[i]  = rst[i];
        end
        #1;
        for (int i = 0; i < 2; i++) check_inst(i);
    end

    // One beat on node 'sel'; the other node sees random data with no start.
    task automatic tick(input int sel, input logic st, input logic [3:0] bits);
        @(negedge clk);
        if (busy_chk >= 0) begin
            cmp("busy_mid_frame", busy_chk, 16'(busy_o[busy_chk]), 16'h1);
            busy_chk = -1;
        end
        for (int i = 0; i < 2; i++) begin
            in_start[i] = 1'b0;
            in_bits[i]  = 4'($urandom);
        end
        in_start[sel] = st;
        in_bits[sel]  = bits;
        last_e = cyc;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 1'b0, 4'($urandom));
    endtask

    task automatic idle_chk(input int sel);
        idle(3);
        cmp("busy_idle", sel, 16'(busy_o[sel]), 16'h0);
    endtask

    task automatic pulse_reset(input int sel);
        busy_chk = -1;
        @(negedge clk);
        rst[sel] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_start[i] = 1'b0;
            in_bits[i]  = 4'($urandom);
        end
        @(negedge clk);
        rst[sel] = 1'b0;
    endtask

    // Builds and drives one frame from the protocol rules; queues the commit it must cause.
    task automatic send_frame(input int sel, input logic [3:0] id, input logic [15:0] pay,
                              input bit bad, input int abort_at);
        int          L, C, nid, npay, n, nv;
        logic [3:0]  lm, b, par, vm;
        bit          hit;
        exp_t        e;
        L    = (sel == 0) ? A_L : B_L;
        C    = (sel == 0) ? A_C : B_C;
        lm   = (sel == 0) ? 4'h1 : 4'hF;
        nid  = (IDW + L - 1) / L;
        npay = (C + L - 1) / L;
        par  = '0;
        n    = 0;
        for (int h = 0; h < nid; h++) begin
            b = 4'(id >> (h * L)) & lm;
            tick(sel, h == 0, b);
            par ^= b;
            n++;
            if (n == 1) busy_chk = sel;
            if (n == abort_at) return;
        end
        for (int k = 0; k < npay; k++) begin
            nv = C - k * L;
            b  = 4'(pay >> (k * L)) & lm;
            if (nv < L) begin
                vm = 4'((1 << nv) - 1);
                b  = (b & vm) | (4'($urandom) & lm & ~vm);
            end
            tick(sel, 1'b0, b);
            par ^= b;
            n++;
            if (n == abort_at) return;
        end
`ifdef CFG_NODE_PARITY_EN
        tick(sel, 1'b0, bad ? (par ^ 4'h1) : par);
`endif
        hit = (id == NODE_ID) || (id == 4'hF);
        if (hit && PAR_EN && bad) begin
            if (err_from[sel] < 0) err_from[sel] = last_e + 1;
        end else if (hit) begin
            e.val = pay & 16'((1 << C) - 1);
            e.cyc = last_e + 2;
            if (sel == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    initial begin
        int       nb;
        logic [3:0] rid;
        for (int i = 0; i < 2; i++) begin
            rst[i]      = 1'b1;
            in_start[i] = 1'b0;
            in_bits[i]  = 4'h0;
            exp_cfg[i]  = '0;
            err_from[i] = -1;
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        idle(2);

        // Single lane node: addressed, foreign, broadcast, abort, back-to-back.
        send_frame(0, 4'h7, 16'h00A5, 1'b0, -1);
        idle_chk(0);
        send_frame(0, 4'h3, 16'h003C, 1'b0, -1);
        idle_chk(0);
        send_frame(0, 4'hF, 16'h005A, 1'b0, -1);
        send_frame(0, 4'h7, 16'h00C3, 1'b0, 6);
        send_frame(0, 4'h7, 16'h0096, 1'b0, -1);
        send_frame(0, 4'h7, 16'h0011, 1'b0, -1);
        idle_chk(0);

        // Four lane node: broadcast with ignored lanes, abort in payload beat 1, parity, reset.
        send_frame(1, 4'hF, 16'h0321, 1'b0, -1);
        idle_chk(1);
        send_frame(1, 4'h7, 16'h02AA, 1'b0, 2);
        send_frame(1, 4'h7, 16'h0155, 1'b0, -1);
        idle_chk(1);
        send_frame(1, 4'h7, 16'h00F0, 1'b1, -1);
        idle_chk(1);
        send_frame(1, 4'h7, 16'h030F, 1'b0, -1);
        send_frame(1, 4'h2, 16'h0000, 1'b1, -1);
        idle_chk(1);
        send_frame(1, 4'h7, 16'h0123, 1'b0, 3);
        pulse_reset(1);
        send_frame(1, 4'hF, 16'h0287, 1'b0, -1);
        send_frame(1, 4'h7, 16'h0199, 1'b0, -1);
        idle_chk(1);

        // Randomised traffic on both nodes.
        for (int sel = 0; sel < 2; sel++) begin
            nb = (sel == 0) ? 12 : 4;
            for (int it = 0; it < 30; it++) begin
                case ($urandom_range(0, 3))
                    0:       rid = 4'h7;
                    1:       rid = 4'hF;
                    default: rid = 4'($urandom);
                endcase
                if ($urandom_range(0, 5) == 0)
                    send_frame(sel, 4'h7, 16'($urandom), 1'b0, $urandom_range(1, nb - 1));
                send_frame(sel, rid, 16'($urandom), $urandom_range(0, 5) == 0, -1);
                idle($urandom_range(0, 2));
            end
            idle_chk(sel);
        end

        idle(4);
        cmp("pending_commits", 0, 16'(q0.size()), 16'h0);
        cmp("pending_commits", 1, 16'(q1.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
